// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared definitions for the data-memory controller.
//   - Access size encodings (byte / half / word / reserved).
//   - Controller FSM state enum.
//   - lane_extract: pull a byte/half/word out of a RAM word and extend it.
//   - lane_merge:   insert a byte/half into a RAM word, leaving other lanes intact.
package bram_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Byte lane n lives in word[8n+7:8n]; a half uses lane[1] to pick its 16-bit slot.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sext);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = 32'h0000_0000;
        res = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                sh  = word >> {lane, 3'b000};
                res = {{24{sext & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                sh  = word >> {lane[1], 4'b0000};
                res = {{16{sext & sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        logic [31:0] ins;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = data << {lane, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = data << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = data;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/bram_ctrl_sp.sv
// bram_sp: single-port synchronous RAM, 32-bit words, 2**DEPTH_LOG2 deep.
//   clk  - clock
//   addr - word address
//   din  - write data
//   wren - write enable
//   dout - registered read data (1-cycle latency, old contents on a same-address write)
// No reset so the array maps onto block RAM.
module bram_sp #(
    parameter int DEPTH_LOG2 = 11,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wren,
    output logic [WIDTH-1:0]      dout
);

    logic [WIDTH-1:0] mem_r [0:(1<<DEPTH_LOG2)-1];

    // Read-before-write port: dout always shows the word as it was before this edge.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/bram_ctrl.sv
// bram_ctrl: byte-addressable data-memory controller over a word RAM.
//   clk, resetn          - clock, asynchronous active-low reset
//   req_valid/req_ready  - request handshake; one outstanding request
//   req_we, req_size, req_sext, req_addr, req_wdata - request fields
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata, rsp_err   - load result (0 for stores/errors), error flag
// Sub-word stores are done as read-modify-write. The RAM is addressed from the
// live request while idle, so read data is already available in RD and the
// response can be registered on the RD -> RESP edge.
module bram_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DEPTH_LOG2 = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    state_t                state_r, state_nxt_s;
    logic [ADDR_W-1:0]     off_s;
    logic [1:0]            lane_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  err_s;
    logic                  accept_s;

    logic [DEPTH_LOG2-1:0] idx_r;
    logic [1:0]            lane_r;
    logic [1:0]            size_r;
    logic                  sext_r;
    logic                  we_r;
    logic [31:0]           wdata_r;

    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [31:0]           rsp_rdata_r;
    logic                  rsp_err_r;

    logic [DEPTH_LOG2-1:0] ram_addr_s;
    logic [31:0]           ram_din_s;
    logic                  ram_wren_s;
    logic [31:0]           ram_dout_s;

    assign accept_s  = req_valid & req_ready_r;
    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // Decode the live request: offset, lane, word index and error flag.
    always_comb begin
        off_s  = req_addr - BASE_ADDR;
        lane_s = off_s[1:0];
        idx_s  = off_s[DEPTH_LOG2+1:2];
        // Addresses below BASE_ADDR wrap to huge offsets and land here too.
        err_s  = |off_s[ADDR_W-1:DEPTH_LOG2+2];
        case (req_size)
            SZ_BYTE: err_s = err_s;
            SZ_HALF: err_s = err_s | lane_s[0];
            SZ_WORD: err_s = err_s | (lane_s != 2'b00);
            default: err_s = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (err_s) begin
                    state_nxt_s = ST_RESP;
                end else if (req_we && (req_size == SZ_WORD)) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD:    state_nxt_s = we_r ? ST_MERGE : ST_RESP;
            ST_MERGE: state_nxt_s = ST_RESP;
            ST_WR:    state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // RAM control: writes only in WR/MERGE, so reset (forcing IDLE) cancels a pending write.
    always_comb begin
        ram_addr_s = (state_r == ST_IDLE) ? idx_s : idx_r;
        ram_wren_s = (state_r == ST_WR) || (state_r == ST_MERGE);
        if (state_r == ST_MERGE) begin
            ram_din_s = lane_merge(ram_dout_s, wdata_r, size_r, lane_r);
        end else begin
            ram_din_s = wdata_r;
        end
    end

    // Capture the request fields on the accept edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_r   <= {DEPTH_LOG2{1'b0}};
            lane_r  <= 2'b00;
            size_r  <= 2'b00;
            sext_r  <= 1'b0;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            idx_r   <= idx_s;
            lane_r  <= lane_s;
            size_r  <= req_size;
            sext_r  <= req_sext;
            we_r    <= req_we;
            wdata_r <= req_wdata;
        end else begin
            idx_r   <= idx_r;
            lane_r  <= lane_r;
            size_r  <= size_r;
            sext_r  <= sext_r;
            we_r    <= we_r;
            wdata_r <= wdata_r;
        end
    end

    // Registered handshake/response outputs, loaded on entry to RESP and held there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if ((state_r != ST_RESP) && (state_nxt_s == ST_RESP)) begin
                rsp_err_r <= (state_r == ST_IDLE);
                if ((state_r == ST_RD) && !we_r) begin
                    rsp_rdata_r <= lane_extract(ram_dout_s, size_r, lane_r, sext_r);
                end else begin
                    rsp_rdata_r <= 32'h0000_0000;
                end
            end else if (state_nxt_s != ST_RESP) begin
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 32'h0000_0000;
            end else begin
                rsp_err_r   <= rsp_err_r;
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    bram_sp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_ram (
        .clk  (clk),
        .addr (ram_addr_s),
        .din  (ram_din_s),
        .wren (ram_wren_s),
        .dout (ram_dout_s)
    );

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed self-checking bench for bram_ctrl (BASE_ADDR=0, DEPTH_LOG2=11).
module tb_bram_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    bram_ctrl #(
        .ADDR_W     (32),
        .DEPTH_LOG2 (11),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = nm; v.we = we; v.size = size; v.sext = sext; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at a negedge after the response has been consumed.
    // lat = number of rising edges from the accept edge (inclusive) until rsp_valid is seen.
    task automatic xact(input string nm, input logic we, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_we = we; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd = 32'h0; er = 1'b0; lat = 0;
        if (!req_ready) begin
            check({nm, "_accept_timeout"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!rsp_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            rd = rsp_rdata;
            er = rsp_err;
            if (rsp_ready) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] held;
        int          n;

        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        //   name          we    size   sext  addr          wdata         rdata         err   lat
        add("st_w_10",     1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2);
        add("ld_w_10",     1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b0, 2);
        add("st_b_12",     1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_0055, 32'h0000_0000, 1'b0, 3);
        add("ld_w_10b",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDE55_BEEF, 1'b0, 2);
        add("ld_b_13_s",   1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'hFFFF_FFDE, 1'b0, 2);
        add("ld_b_13_z",   1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h0000_00DE, 1'b0, 2);
        add("st_h_10",     1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'h0000_8001, 32'h0000_0000, 1'b0, 3);
        add("ld_w_10c",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDE55_8001, 1'b0, 2);
        add("ld_h_10_s",   1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFF_8001, 1'b0, 2);
        add("ld_h_12_z",   1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h0000_DE55, 1'b0, 2);
        add("ld_b_12_s",   1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        32'h0000_0055, 1'b0, 2);
        add("ld_w_11_err", 1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1, 1);
        add("st_h_13_err", 1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_1234, 32'h0000_0000, 1'b1, 1);
        add("ld_w_10d",    1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDE55_8001, 1'b0, 2);
        add("ld_2000_err", 1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,        32'h0000_0000, 1'b1, 1);
        add("st_2000_err", 1'b1, 2'b10, 1'b0, 32'h0000_2000, 32'h1111_1111, 32'h0000_0000, 1'b1, 1);
        add("rsvd_err",    1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1, 1);
        add("st_w_1ffc",   1'b1, 2'b10, 1'b0, 32'h0000_1FFC, 32'h1234_5678, 32'h0000_0000, 1'b0, 2);
        add("ld_w_1ffc",   1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,        32'h1234_5678, 1'b0, 2);
        add("ld_b_1fff",   1'b0, 2'b00, 1'b0, 32'h0000_1FFF, 32'h0,        32'h0000_0012, 1'b0, 2);
        add("ld_h_1ffe_s", 1'b0, 2'b01, 1'b1, 32'h0000_1FFE, 32'h0,        32'h0000_1234, 1'b0, 2);
        add("ld_w_0",      1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0, 2);
        add("st_w_0",      1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 2);
        add("ld_w_1ffc_b", 1'b0, 2'b10, 1'b0, 32'h0000_1FFC, 32'h0,        32'h1234_5678, 1'b0, 2);

        // ld_w_0 reads an unwritten word; drop it from rdata checking by writing first.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].name == "ld_w_0") begin
                xact("prime_0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
            end
            xact(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr,
                 vecs[i].wdata, rd, er, lat);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_err"},   32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].exp_lat));
        end

        // Backpressure: hold rsp_ready low for 5 cycles with a second request waiting.
        rsp_ready = 1'b0;
        xact("bp_ld", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check("bp_first_rdata", rd, 32'hDE55_8001);
        held = rsp_rdata;
        req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0; req_addr = 32'h0000_0013; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rdata", rsp_rdata, held);
            check("bp_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(rsp_valid), 32'h0);
        check("bp_ready_back", 32'(req_ready), 32'h1);
        xact("bp_next", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, rd, er, lat);
        check("bp_next_rdata", rd, 32'h0000_00DE);
        check("bp_next_lat", 32'(lat), 32'h2);

        // Reset during MERGE of a byte store must cancel the write.
        req_we = 1'b1; req_size = 2'b00; req_sext = 1'b0; req_addr = 32'h0000_0010;
        req_wdata = 32'h0000_00AA; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mr_accept", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mr_rst_ready", 32'(req_ready), 32'h0);
        check("mr_rst_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        check("mr_rst_ready2", 32'(req_ready), 32'h0);
        check("mr_rst_valid2", 32'(rsp_valid), 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mr_no_rsp", 32'(rsp_valid), 32'h0);
        end
        xact("mr_reread", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check("mr_reread_rdata", rd, 32'hDE55_8001);
        check("mr_reread_err", 32'(er), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
